ptw_arbiter: RTL and testbench
==============================

Name: ptw_arbiter

Overview:
- Shares the single page-table walker (PTW) between the instruction-side and data-side TLB miss paths.
- Sequences each walk: grant, issue, wait, respond.
- Returns the PTE or fault to the winning requester.
- Drives the stall_IMEM/stall_DMEM inputs of the hazard unit and cancels in-flight walks on a pipeline flush (FLUSH_ALL).

Parameters:
- STARVE_LIMIT, 4: consecutive DMEM grants allowed while IMEM waits before IMEM is forced to win.
- TIMEOUT, 256: max cycles in WAIT before a walk is aborted as a fault; 0 disables the watchdog.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  pipeline flush (hazard_signal == FLUSH_ALL); cancels pending/in-flight walk.
- imem_req  input  1  IMEM TLB miss; level, held until imem_done or flush.
- imem_va  input  32  IMEM faulting virtual address.
- imem_done  output  1  one-cycle response pulse to IMEM.
- imem_pte  output  32  PTE returned with imem_done.
- imem_fault  output  1  instruction page fault, valid with imem_done (to instr_fault_mmu_IMEM).
- dmem_req  input  1  DMEM TLB miss; level.
- dmem_va  input  32  DMEM virtual address.
- dmem_store  input  1  1 = store access, 0 = load access.
- dmem_done  output  1  one-cycle response pulse to DMEM.
- dmem_pte  output  32  PTE returned with dmem_done.
- dmem_load_fault  output  1  load page fault, valid with dmem_done.
- dmem_store_fault  output  1  store page fault, valid with dmem_done.
- ptw_req  output  1  walk request; held until ptw_ready.
- ptw_va  output  32  latched VA of the granted requester.
- ptw_acc  output  2  access type: 00 fetch, 01 load, 10 store.
- ptw_ready  input  1  walker accepts the request this cycle.
- ptw_done  input  1  walker result valid (single-cycle).
- ptw_pte  input  32  walker result PTE.
- ptw_fault  input  1  walker result is a fault.
- stall_IMEM  output  1  imem_req & ~imem_done.
- stall_DMEM  output  1  dmem_req & ~dmem_done.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; owner, starve_cnt, timer, cancel cleared.
  - ptw_req=0, ptw_va=0, ptw_acc=00.
  - All done/fault outputs 0; imem_pte=dmem_pte=0.
  - Reset mid-walk drops the walk silently; no done pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If flush=0 and any req is high: pick the owner, register va/acc, go ISSUE. ptw_req rises the next cycle (1-cycle grant latency).
  - Arbitration: DMEM wins by default (older instruction).
  - IMEM wins if only imem_req is high, or if both are high and starve_cnt == STARVE_LIMIT.
- starve_cnt:
  - Increments on a DMEM grant while imem_req=1, saturating at STARVE_LIMIT.
  - Clears on an IMEM grant, or whenever imem_req=0.
- ISSUE:
  - ptw_req=1 with stable ptw_va/ptw_acc.
  - On ptw_ready: go WAIT, clear timer.
  - flush while in ISSUE: deassert ptw_req, return to IDLE, no response.
- WAIT:
  - Timer increments each cycle.
  - On ptw_done: latch pte/fault and go RESP. If cancel is set, discard the result and go IDLE instead.
  - flush while in WAIT sets cancel; the walker cannot be aborted, so the FSM stays in WAIT until ptw_done.
  - Timer reaching TIMEOUT (if nonzero) is treated as ptw_done with fault=1 and pte=0. A later stray ptw_done in IDLE is ignored.
- RESP (one cycle):
  - owner_done = ~flush, carrying the latched pte and fault.
  - Fault routing: IMEM → imem_fault; DMEM → dmem_store_fault if acc=10, else dmem_load_fault.
  - Fault outputs are 0 whenever the corresponding done is 0.
  - Next state is IDLE. A new grant is possible from IDLE the cycle after RESP (no back-to-back issue from RESP).
- Simultaneous events:
  - flush and ptw_done in the same WAIT cycle: result discarded.
  - A req that drops while its walk is in flight: the response is still issued (requester ignores it); no cancel unless flush.
- Owner mux: pte/done outputs of the non-owner are held 0.

Test Plan:
- Single IMEM miss, imem_va=0x0000_4000, ptw_ready immediate, ptw_done 3 cycles later with pte=0x2000_00CF → ptw_req at cycle 1, ptw_acc=00, imem_done 1 cycle after ptw_done with imem_pte=0x2000_00CF; stall_IMEM high for the whole duration until done.
- Both requesters high, DMEM store dmem_va=0x8000_1000 → DMEM granted first with ptw_acc=10. A ptw_fault=1 result → dmem_store_fault=1, dmem_load_fault=0, IMEM granted next.
- DMEM request held continuously with IMEM pending, STARVE_LIMIT=4 → grant order D,D,D,D,I; starve_cnt returns to 0.
- flush in ISSUE before ptw_ready → ptw_req drops the next cycle, no done. flush during WAIT, then ptw_done → no done pulse, FSM back in IDLE.
- TIMEOUT=8, ptw_ready but no ptw_done → done pulse 9 cycles after accept with fault=1, pte=0.
- rst asserted low during WAIT → all outputs 0 immediately (asynchronously). After release, a new request is granted normally.

Source files
------------

// File: rtl/ptw_arbiter.sv
// Arbitrates the shared page-table walker between the IMEM and DMEM TLB miss paths.
// Each walk is sequenced as grant -> issue -> wait -> respond. A pipeline flush cancels the walk.
module ptw_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        imem_req,
  input  logic [31:0] imem_va,
  output logic        imem_done,
  output logic [31:0] imem_pte,
  output logic        imem_fault,
  input  logic        dmem_req,
  input  logic [31:0] dmem_va,
  input  logic        dmem_store,
  output logic        dmem_done,
  output logic [31:0] dmem_pte,
  output logic        dmem_load_fault,
  output logic        dmem_store_fault,
  output logic        ptw_req,
  output logic [31:0] ptw_va,
  output logic [1:0]  ptw_acc,
  input  logic        ptw_ready,
  input  logic        ptw_done,
  input  logic [31:0] ptw_pte,
  input  logic        ptw_fault,
  output logic        stall_IMEM,
  output logic        stall_DMEM
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            TMO_EN     = (TIMEOUT != 0);

  localparam logic [1:0] ACC_FETCH = 2'b00;
  localparam logic [1:0] ACC_LOAD  = 2'b01;
  localparam logic [1:0] ACC_STORE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_next;
  logic            r_owner_d;
  logic [31:0]     r_va;
  logic [1:0]      r_acc;
  logic [SW-1:0]   r_starve;
  logic [TW-1:0]   r_timer;
  logic            r_cancel;
  logic [31:0]     r_pte;
  logic            r_fault;

  logic w_grant_any, w_grant_i, w_timeout, w_result, w_resp;

  assign w_grant_any = ~flush & (imem_req | dmem_req);
  assign w_grant_i   = imem_req & (~dmem_req | (r_starve == STARVE_MAX));
  assign w_timeout   = TMO_EN && (r_timer == TMO_LAST);
  assign w_result    = ptw_done | w_timeout;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_any) w_next = S_ISSUE;
      // The walker has already accepted the request when flush and ready coincide, so the walk must be drained.
      S_ISSUE: if (ptw_ready) w_next = S_WAIT;
               else if (flush) w_next = S_IDLE;
      S_WAIT:  if (w_result) w_next = (r_cancel | flush) ? S_IDLE : S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_owner_d <= 1'b0;
      r_va      <= '0;
      r_acc     <= ACC_FETCH;
      r_starve  <= '0;
      r_timer   <= '0;
      r_cancel  <= 1'b0;
      r_pte     <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == S_IDLE && w_grant_any) begin
        r_owner_d <= ~w_grant_i;
        r_va      <= w_grant_i ? imem_va : dmem_va;
        r_acc     <= w_grant_i ? ACC_FETCH : (dmem_store ? ACC_STORE : ACC_LOAD);
      end

      if (!imem_req)
        r_starve <= '0;
      else if (r_state == S_IDLE && w_grant_any)
        r_starve <= w_grant_i ? '0 : ((r_starve == STARVE_MAX) ? STARVE_MAX : r_starve + 1'b1);

      if (r_state == S_ISSUE && ptw_ready) begin
        r_timer  <= '0;
        r_cancel <= flush;
      end

      if (r_state == S_WAIT) begin
        r_timer <= r_timer + 1'b1;
        if (flush) r_cancel <= 1'b1;
        if (w_result) begin
          r_cancel <= 1'b0;
          // A genuine result wins over a watchdog expiry landing in the same cycle.
          r_pte    <= ptw_done ? ptw_pte : '0;
          r_fault  <= ptw_done ? ptw_fault : 1'b1;
        end
      end
    end
  end

  assign w_resp    = (r_state == S_RESP) & ~flush;
  assign imem_done = w_resp & ~r_owner_d;
  assign dmem_done = w_resp & r_owner_d;
  assign imem_pte  = imem_done ? r_pte : '0;
  assign dmem_pte  = dmem_done ? r_pte : '0;

  assign imem_fault       = imem_done & r_fault;
  assign dmem_store_fault = dmem_done & r_fault & (r_acc == ACC_STORE);
  assign dmem_load_fault  = dmem_done & r_fault & (r_acc != ACC_STORE);

  assign ptw_req = (r_state == S_ISSUE);
  assign ptw_va  = r_va;
  assign ptw_acc = r_acc;

  assign stall_IMEM = imem_req & ~imem_done;
  assign stall_DMEM = dmem_req & ~dmem_done;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Self-checking bench for ptw_arbiter: directed vector table, hand-written corner sequences,
// and randomized walks checked against a transaction-level arbitration model.
module tb_ptw_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;

  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic        imem_req = 1'b0, dmem_req = 1'b0, dmem_store = 1'b0;
  logic [31:0] imem_va = '0, dmem_va = '0, ptw_pte = '0;
  logic        ptw_ready = 1'b0, ptw_done = 1'b0, ptw_fault = 1'b0;
  logic        imem_done, imem_fault, dmem_done, dmem_load_fault, dmem_store_fault;
  logic [31:0] imem_pte, dmem_pte, ptw_va;
  logic        ptw_req, stall_IMEM, stall_DMEM;
  logic [1:0]  ptw_acc;

  ptw_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .imem_req(imem_req), .imem_va(imem_va), .imem_done(imem_done), .imem_pte(imem_pte),
    .imem_fault(imem_fault),
    .dmem_req(dmem_req), .dmem_va(dmem_va), .dmem_store(dmem_store), .dmem_done(dmem_done),
    .dmem_pte(dmem_pte), .dmem_load_fault(dmem_load_fault), .dmem_store_fault(dmem_store_fault),
    .ptw_req(ptw_req), .ptw_va(ptw_va), .ptw_acc(ptw_acc), .ptw_ready(ptw_ready),
    .ptw_done(ptw_done), .ptw_pte(ptw_pte), .ptw_fault(ptw_fault),
    .stall_IMEM(stall_IMEM), .stall_DMEM(stall_DMEM)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        issue_ok;
    logic [31:0] va;
    logic [1:0]  acc;
    logic        stall_i;
    logic        stall_d;
    int          n;
    logic        idone, ddone;
    logic [31:0] ipte, dpte;
    logic        ifl, dlf, dsf, req_resp;
  } obs_t;

  typedef struct {
    logic [1:0]  acc;
    logic [31:0] va;
    int          n;
    logic        idone, ddone;
    logic [31:0] pte;
    logic        ifl, dlf, dsf;
  } exp_t;

  typedef struct {
    logic        ireq, dreq, dst;
    logic [31:0] iva, dva;
    int          rdly, ddly;
    logic [31:0] pte;
    logic        flt;
    exp_t        e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle with requests already driven; returns during the response cycle.
  // ddly < 0 means the walker never answers.
  task automatic run_walk(input int rdly, input int ddly, input logic [31:0] pte,
                          input logic flt, output obs_t o);
    o.n = -1; o.idone = 0; o.ddone = 0; o.ipte = '0; o.dpte = '0;
    o.ifl = 0; o.dlf = 0; o.dsf = 0; o.req_resp = 1'b1;
    cyc(); #1;
    o.issue_ok = ptw_req; o.va = ptw_va; o.acc = ptw_acc;
    o.stall_i = stall_IMEM; o.stall_d = stall_DMEM;
    for (int k = 0; k < rdly; k++) begin
      cyc(); #1;
      o.issue_ok &= ptw_req; o.stall_i &= stall_IMEM; o.stall_d &= stall_DMEM;
    end
    ptw_ready = 1'b1;
    cyc();
    ptw_ready = 1'b0;
    for (int n = 0; n < 64; n++) begin
      ptw_done = (n == ddly); ptw_pte = pte; ptw_fault = flt;
      #1;
      if (imem_done | dmem_done) begin
        o.n = n; o.idone = imem_done; o.ddone = dmem_done;
        o.ipte = imem_pte; o.dpte = dmem_pte;
        o.ifl = imem_fault; o.dlf = dmem_load_fault; o.dsf = dmem_store_fault;
        o.req_resp = ptw_req;
        break;
      end
      o.stall_i &= stall_IMEM; o.stall_d &= stall_DMEM;
      cyc();
    end
    ptw_done = 1'b0;
  endtask

  task automatic check_walk(input string tag, input obs_t o, input exp_t e);
    check($sformatf("%s.issue", tag), 32'(o.issue_ok), 32'(1));
    check($sformatf("%s.va", tag), o.va, e.va);
    check($sformatf("%s.acc", tag), 32'(o.acc), 32'(e.acc));
    check($sformatf("%s.latency", tag), 32'(o.n), 32'(e.n));
    check($sformatf("%s.idone", tag), 32'(o.idone), 32'(e.idone));
    check($sformatf("%s.ddone", tag), 32'(o.ddone), 32'(e.ddone));
    check($sformatf("%s.ipte", tag), o.ipte, e.idone ? e.pte : 32'h0);
    check($sformatf("%s.dpte", tag), o.dpte, e.ddone ? e.pte : 32'h0);
    check($sformatf("%s.ifault", tag), 32'(o.ifl), 32'(e.ifl));
    check($sformatf("%s.dlfault", tag), 32'(o.dlf), 32'(e.dlf));
    check($sformatf("%s.dsfault", tag), 32'(o.dsf), 32'(e.dsf));
    check($sformatf("%s.req_resp", tag), 32'(o.req_resp), 32'(0));
    check($sformatf("%s.stall_i", tag), 32'(o.stall_i), 32'(imem_req));
    check($sformatf("%s.stall_d", tag), 32'(o.stall_d), 32'(dmem_req));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[6];
    obs_t        o;
    exp_t        e;
    logic [1:0]  acc_seq[6];
    logic        ipend, dpend, dst, win_i, tmo, flt, f_eff;
    logic [31:0] iva, dva, pte;
    int          m_starve, ddly;

    tbl[0] = '{ireq:1, dreq:0, dst:0, iva:32'h0000_4000, dva:32'h0, rdly:0, ddly:2,
               pte:32'h2000_00CF, flt:0,
               e:'{acc:2'b00, va:32'h0000_4000, n:3, idone:1, ddone:0, pte:32'h2000_00CF,
                   ifl:0, dlf:0, dsf:0}};
    tbl[1] = '{ireq:0, dreq:1, dst:0, iva:32'h0, dva:32'h1234_5678, rdly:1, ddly:0,
               pte:32'hAAAA_5555, flt:1,
               e:'{acc:2'b01, va:32'h1234_5678, n:1, idone:0, ddone:1, pte:32'hAAAA_5555,
                   ifl:0, dlf:1, dsf:0}};
    tbl[2] = '{ireq:0, dreq:1, dst:1, iva:32'h0, dva:32'h8000_1000, rdly:2, ddly:4,
               pte:32'h0F0F_0F0F, flt:0,
               e:'{acc:2'b10, va:32'h8000_1000, n:5, idone:0, ddone:1, pte:32'h0F0F_0F0F,
                   ifl:0, dlf:0, dsf:0}};
    tbl[3] = '{ireq:1, dreq:1, dst:1, iva:32'h00AB_C000, dva:32'h8000_1000, rdly:0, ddly:1,
               pte:32'h1111_1111, flt:1,
               e:'{acc:2'b10, va:32'h8000_1000, n:2, idone:0, ddone:1, pte:32'h1111_1111,
                   ifl:0, dlf:0, dsf:1}};
    tbl[4] = '{ireq:1, dreq:0, dst:0, iva:32'hFFFF_F000, dva:32'h0, rdly:0, ddly:-1,
               pte:32'hDEAD_BEEF, flt:0,
               e:'{acc:2'b00, va:32'hFFFF_F000, n:TIMEOUT, idone:1, ddone:0, pte:32'h0,
                   ifl:1, dlf:0, dsf:0}};
    tbl[5] = '{ireq:0, dreq:1, dst:0, iva:32'h0, dva:32'h0000_0004, rdly:1, ddly:-1,
               pte:32'hDEAD_BEEF, flt:0,
               e:'{acc:2'b01, va:32'h0000_0004, n:TIMEOUT, idone:0, ddone:1, pte:32'h0,
                   ifl:0, dlf:1, dsf:0}};

    // Reset state
    imem_req = 1'b1; imem_va = 32'h1234_0000;
    cyc(); cyc(); #1;
    check("rst.ptw_req", 32'(ptw_req), 32'(0));
    check("rst.ptw_va", ptw_va, 32'h0);
    check("rst.ptw_acc", 32'(ptw_acc), 32'(0));
    check("rst.done", 32'({imem_done, dmem_done}), 32'(0));
    check("rst.pte", imem_pte | dmem_pte, 32'h0);
    check("rst.fault", 32'({imem_fault, dmem_load_fault, dmem_store_fault}), 32'(0));
    imem_req = 1'b0;
    cyc();
    rst = 1'b1;

    // Directed vectors, each starting from IDLE with both requests dropped
    for (int i = 0; i < 6; i++) begin
      cyc();
      imem_req = 1'b0; dmem_req = 1'b0;
      cyc();
      imem_req = tbl[i].ireq; imem_va = tbl[i].iva;
      dmem_req = tbl[i].dreq; dmem_va = tbl[i].dva; dmem_store = tbl[i].dst;
      run_walk(tbl[i].rdly, tbl[i].ddly, tbl[i].pte, tbl[i].flt, o);
      check_walk($sformatf("vec%0d", i), o, tbl[i].e);
    end

    // Stray walker result after a timeout is ignored in IDLE
    cyc();
    imem_req = 1'b0; dmem_req = 1'b0;
    ptw_done = 1'b1; ptw_fault = 1'b1; ptw_pte = 32'h5555_AAAA;
    cyc();
    ptw_done = 1'b0; #1;
    check("stray.done", 32'({imem_done, dmem_done}), 32'(0));
    check("stray.req", 32'(ptw_req), 32'(0));

    // Both pending: DMEM store faults first, then IMEM is served
    cyc();
    imem_req = 1'b1; imem_va = 32'h0000_4000;
    dmem_req = 1'b1; dmem_va = 32'h8000_1000; dmem_store = 1'b1;
    run_walk(0, 1, 32'h0000_0001, 1'b1, o);
    e = '{acc:2'b10, va:32'h8000_1000, n:2, idone:0, ddone:1, pte:32'h0000_0001,
          ifl:0, dlf:0, dsf:1};
    check_walk("both.d", o, e);
    cyc();
    dmem_req = 1'b0;
    run_walk(0, 0, 32'h2000_00CF, 1'b0, o);
    e = '{acc:2'b00, va:32'h0000_4000, n:1, idone:1, ddone:0, pte:32'h2000_00CF,
          ifl:0, dlf:0, dsf:0};
    check_walk("both.i", o, e);

    // Starvation: D,D,D,D,I then the counter restarts so D wins again
    cyc();
    imem_req = 1'b0; dmem_req = 1'b0;
    cyc();
    imem_req = 1'b1; imem_va = 32'h0000_9000;
    dmem_req = 1'b1; dmem_va = 32'h0000_A000; dmem_store = 1'b0;
    for (int g = 0; g < 6; g++) begin
      run_walk(0, 0, 32'(g), 1'b0, o);
      acc_seq[g] = o.acc;
      cyc();
    end
    for (int g = 0; g < 6; g++)
      check($sformatf("starve.grant%0d", g), 32'(acc_seq[g]), (g == 4) ? 32'(0) : 32'(1));

    // Flush while ISSUE: request drops next cycle and nothing is answered
    imem_req = 1'b0; dmem_req = 1'b0;
    cyc();
    imem_req = 1'b1; imem_va = 32'h0000_3000;
    cyc(); #1;
    check("fli.req", 32'(ptw_req), 32'(1));
    flush = 1'b1;
    cyc();
    flush = 1'b0; imem_req = 1'b0; #1;
    check("fli.req_drop", 32'(ptw_req), 32'(0));
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      check($sformatf("fli.quiet%0d", k), 32'({imem_done, dmem_done, ptw_req}), 32'(0));
    end

    // Flush while WAIT: walk drains silently, then a new request is granted
    dmem_req = 1'b1; dmem_store = 1'b0; dmem_va = 32'h0000_2000;
    cyc();
    ptw_ready = 1'b1;
    cyc();
    ptw_ready = 1'b0; flush = 1'b1; dmem_req = 1'b0;
    cyc();
    flush = 1'b0;
    cyc();
    ptw_done = 1'b1; ptw_pte = 32'h0000_0005; ptw_fault = 1'b0;
    cyc();
    ptw_done = 1'b0; #1;
    check("flw.nodone", 32'({imem_done, dmem_done}), 32'(0));
    check("flw.noreq", 32'(ptw_req), 32'(0));
    imem_req = 1'b1; imem_va = 32'h0000_8000;
    cyc(); #1;
    check("flw.regrant", 32'(ptw_req), 32'(1));
    check("flw.regrant_va", ptw_va, 32'h0000_8000);
    ptw_ready = 1'b1;
    cyc();
    ptw_ready = 1'b0; ptw_done = 1'b1; ptw_pte = 32'h0000_1234;
    cyc();
    ptw_done = 1'b0; #1;
    check("flw.done", 32'(imem_done), 32'(1));
    check("flw.pte", imem_pte, 32'h0000_1234);
    imem_req = 1'b0;
    cyc();

    // Flush and walker result in the same WAIT cycle: result discarded
    dmem_req = 1'b1;
    cyc();
    ptw_ready = 1'b1;
    cyc();
    ptw_ready = 1'b0; flush = 1'b1; dmem_req = 1'b0; ptw_done = 1'b1;
    cyc();
    flush = 1'b0; ptw_done = 1'b0; #1;
    check("flsame.nodone", 32'({imem_done, dmem_done}), 32'(0));
    cyc(); #1;
    check("flsame.idle", 32'({imem_done, dmem_done, ptw_req}), 32'(0));

    // Asynchronous reset during WAIT
    dmem_req = 1'b1; dmem_store = 1'b1; dmem_va = 32'hCAFE_0000;
    cyc();
    ptw_ready = 1'b1;
    cyc();
    ptw_ready = 1'b0; #1;
    check("arst.pre_va", ptw_va, 32'hCAFE_0000);
    #2 rst = 1'b0;
    #1;
    check("arst.va", ptw_va, 32'h0);
    check("arst.acc", 32'(ptw_acc), 32'(0));
    check("arst.outs", 32'({ptw_req, imem_done, dmem_done, dmem_store_fault}), 32'(0));
    dmem_req = 1'b0;
    cyc();
    rst = 1'b1; ptw_done = 1'b1;
    cyc();
    ptw_done = 1'b0; #1;
    check("arst.nodone", 32'({imem_done, dmem_done}), 32'(0));
    dmem_req = 1'b1; dmem_store = 1'b0; dmem_va = 32'h0000_1000;
    run_walk(0, 0, 32'h0000_0077, 1'b0, o);
    e = '{acc:2'b01, va:32'h0000_1000, n:1, idone:0, ddone:1, pte:32'h0000_0077,
          ifl:0, dlf:0, dsf:0};
    check_walk("arst.walk", o, e);

    // Randomized walks against a transaction-level model
    cyc();
    imem_req = 1'b0; dmem_req = 1'b0;
    cyc();
    m_starve = 0; ipend = 1'b0; dpend = 1'b0; iva = '0; dva = '0; dst = 1'b0;
    for (int w = 0; w < 60; w++) begin
      if (!ipend && $urandom_range(0, 1) == 1) begin ipend = 1'b1; iva = $urandom; end
      if (!dpend && $urandom_range(0, 2) != 0) begin
        dpend = 1'b1; dva = $urandom; dst = 1'($urandom_range(0, 1));
      end
      if (!ipend && !dpend) begin ipend = 1'b1; iva = $urandom; end
      imem_req = ipend; imem_va = iva;
      dmem_req = dpend; dmem_va = dva; dmem_store = dst;

      win_i = ipend && (!dpend || m_starve == STARVE_LIMIT);
      if (win_i || !ipend) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;

      tmo  = ($urandom_range(0, 7) == 0);
      ddly = tmo ? -1 : int'($urandom_range(0, 5));
      pte  = $urandom;
      flt  = ($urandom_range(0, 3) == 0);
      f_eff = tmo | flt;
      e.acc   = win_i ? 2'b00 : (dst ? 2'b10 : 2'b01);
      e.va    = win_i ? iva : dva;
      e.n     = tmo ? TIMEOUT : ddly + 1;
      e.idone = win_i;
      e.ddone = !win_i;
      e.pte   = tmo ? 32'h0 : pte;
      e.ifl   = win_i & f_eff;
      e.dlf   = !win_i & f_eff & !dst;
      e.dsf   = !win_i & f_eff & dst;

      run_walk(int'($urandom_range(0, 2)), ddly, pte, flt, o);
      check_walk($sformatf("rnd%0d", w), o, e);
      if (win_i) ipend = 1'b0;
      else dpend = 1'b0;
      cyc();
      imem_req = ipend; dmem_req = dpend;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
